// File: rtl/fifo_packer_pkg.sv
// rtl/fifo_packer_pkg.sv - state encoding and width helper shared by fifo_packer files
package fifo_packer_pkg;

   typedef enum logic {
      S_FILL = 1'b0,
      S_HOLD = 1'b1
   } state_t;

   function automatic int f_log2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo_packer_lane_reg.sv
// rtl/fifo_packer_lane_reg.sv - one WIDTH-bit lane of the packed word, write-enable plus clear
module fifo_packer_lane_reg #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_we,
   input  logic             i_clr,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_q <= '0;
      end else if (i_we) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/fifo_packer.sv
// rtl/fifo_packer.sv - packs 2^RATIO_LOG FWFT FIFO words into one valid/ready output word
// PACKER_FLUSH_EN adds the flush port for emitting partial words.
module fifo_packer
   import fifo_packer_pkg::*;
#(
   parameter int RATIO_LOG = 1,
   parameter int WIDTH     = 32
) (
   input  logic                              CLK,
   input  logic                              RST,
   output logic                              fifo_deq,
   input  logic [WIDTH-1:0]                  fifo_dot,
   input  logic                              fifo_emp,
`ifdef PACKER_FLUSH_EN
   input  logic                              flush,
`endif
   output logic [(1<<RATIO_LOG)*WIDTH-1:0]   out_data,
   output logic [RATIO_LOG:0]                out_cnt,
   output logic                              out_valid,
   input  logic                              out_ready
);

   localparam int RATIO = 1 << RATIO_LOG;
   localparam int CNT_W = f_log2(RATIO) + 1;
   localparam logic [RATIO_LOG-1:0] IDX_LAST = RATIO_LOG'(RATIO - 1);
   localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(RATIO);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [RATIO_LOG-1:0] r_idx;
   logic [RATIO_LOG-1:0] w_idx_nxt;
   logic                 r_valid;
   logic                 w_valid_nxt;
   logic [CNT_W-1:0]     r_cnt;
   logic [CNT_W-1:0]     w_cnt_nxt;
   logic [CNT_W-1:0]     w_cnt_cap;
   logic                 w_deq;
   logic                 w_flush;

`ifdef PACKER_FLUSH_EN
   assign w_flush = flush;
`else
   assign w_flush = 1'b0;
`endif

   assign w_deq = ~RST & ~fifo_emp & ((r_state == S_FILL) | out_ready);

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_valid_nxt = r_valid;
      w_cnt_nxt   = r_cnt;
      // words held once this edge's capture (if any) lands
      w_cnt_cap   = {1'b0, r_idx} + CNT_W'(w_deq);
      case (r_state)
         S_FILL: begin
            if (w_deq) w_idx_nxt = r_idx + 1'b1;
            if (w_deq && (r_idx == IDX_LAST)) begin
               w_state_nxt = S_HOLD;
               w_valid_nxt = 1'b1;
               w_cnt_nxt   = CNT_FULL;
            end else if (w_flush && (w_cnt_cap != '0)) begin
               w_state_nxt = S_HOLD;
               w_valid_nxt = 1'b1;
               w_cnt_nxt   = w_cnt_cap;
               w_idx_nxt   = '0;
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               w_state_nxt = S_FILL;
               w_valid_nxt = 1'b0;
               w_idx_nxt   = w_deq ? RATIO_LOG'(1) : '0;
            end
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_FILL;
         r_idx   <= '0;
         r_valid <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_valid <= w_valid_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // starting a new word at lane 0 wipes the rest so unfilled lanes read zero
   for (genvar i = 0; i < RATIO; i++) begin : g_lane
      logic w_we;
      logic w_clr;
      assign w_we  = w_deq && (r_idx == RATIO_LOG'(i));
      assign w_clr = (i != 0) && w_deq && (r_idx == '0);
      fifo_packer_lane_reg #(.WIDTH(WIDTH)) u_lane (
         .i_clk (CLK),
         .i_rst (RST),
         .i_we  (w_we),
         .i_clr (w_clr),
         .i_d   (fifo_dot),
         .o_q   (out_data[i*WIDTH +: WIDTH])
      );
   end

   assign fifo_deq  = w_deq;
   assign out_valid = r_valid;
   assign out_cnt   = r_cnt;

endmodule

// File: tb/tb_fifo_packer.sv
// tb/tb_fifo_packer.sv - self-checking bench for fifo_packer at RATIO_LOG=1 and RATIO_LOG=2
module tb_fifo_packer;

   localparam int W = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [W-1:0]  dot [2];
   logic          emp [2];
   logic          rdy [2];
`ifdef PACKER_FLUSH_EN
   logic          fl  [2];
`endif

   logic          deq0, deq1, ov0, ov1;
   logic [63:0]   od0;
   logic [127:0]  od1;
   logic [1:0]    oc0;
   logic [2:0]    oc1;

   fifo_packer #(.RATIO_LOG(1), .WIDTH(W)) u_dut0 (
      .CLK(clk), .RST(rst), .fifo_deq(deq0), .fifo_dot(dot[0]), .fifo_emp(emp[0]),
`ifdef PACKER_FLUSH_EN
      .flush(fl[0]),
`endif
      .out_data(od0), .out_cnt(oc0), .out_valid(ov0), .out_ready(rdy[0]));

   fifo_packer #(.RATIO_LOG(2), .WIDTH(W)) u_dut1 (
      .CLK(clk), .RST(rst), .fifo_deq(deq1), .fifo_dot(dot[1]), .fifo_emp(emp[1]),
`ifdef PACKER_FLUSH_EN
      .flush(fl[1]),
`endif
      .out_data(od1), .out_cnt(oc1), .out_valid(ov1), .out_ready(rdy[1]));

   // Model: every word ever pushed, in order. rd = FIFO head, er = oldest word not yet
   // delivered in an accepted packed word; grp = size of the next expected packed word.
   logic [W-1:0] mem [2][2048];
   int wr [2], rd [2], er [2], grp [2], acc [2];
   logic pv [2], pacc [2], pdq [2];
   int nchk = 0, nerr = 0;

   function automatic int ratio(int d);
      return (d == 0) ? 2 : 4;
   endfunction

   task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
      nchk++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] expect_word(int d, int n);
      logic [127:0] w;
      w = '0;
      for (int k = 0; k < n; k++) w[k*32 +: 32] = mem[d][er[d] + k];
      return w;
   endfunction

   task automatic upd();
      for (int d = 0; d < 2; d++) begin
         emp[d] = (rd[d] == wr[d]);
         dot[d] = emp[d] ? 32'hDEADBEEF : mem[d][rd[d]];
      end
   endtask

   task automatic push(int d, logic [W-1:0] val);
      mem[d][wr[d]] = val;
      wr[d]++;
      upd();
   endtask

   task automatic tick();
      logic v, dq;
      logic [127:0] data;
      int cnt;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         v    = (d == 0) ? ov0 : ov1;
         dq   = (d == 0) ? deq0 : deq1;
         data = (d == 0) ? {64'b0, od0} : od1;
         cnt  = (d == 0) ? int'(oc0) : int'(oc1);
         chk($sformatf("deq%0d", d), dq, !rst && !emp[d] && (!v || rdy[d]));
         if (pv[d] && !pacc[d] && !rst) chk($sformatf("valid_held%0d", d), v, 1);
         if (v) begin
            chk($sformatf("valid_has_words%0d", d), (rd[d] - er[d]) >= grp[d], 1);
            chk($sformatf("data%0d", d), data, expect_word(d, grp[d]));
            chk($sformatf("cnt%0d", d), cnt, grp[d]);
         end
         pacc[d] = v && rdy[d] && !rst;
         pv[d]   = v;
         pdq[d]  = dq;
      end
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            er[d]  = rd[d];
            grp[d] = ratio(d);
            pv[d]  = 1'b0;
         end else begin
            if (pacc[d]) begin
               er[d] += grp[d];
               grp[d] = ratio(d);
               acc[d]++;
            end
            if (pdq[d]) rd[d]++;
         end
      end
      #1 upd();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         wr[d] = 0; rd[d] = 0; er[d] = 0; acc[d] = 0; grp[d] = ratio(d);
         pv[d] = 0; pacc[d] = 0; pdq[d] = 0; rdy[d] = 1'b0;
`ifdef PACKER_FLUSH_EN
         fl[d] = 1'b0;
`endif
      end
      upd();
      push(0, 1);
      push(1, 1);
      repeat (3) tick();
      chk("rst_valid0", ov0, 0);
      chk("rst_data0", od0, 0);
      chk("rst_cnt0", oc0, 0);
      chk("rst_deq0", deq0, 0);
      chk("rst_valid1", ov1, 0);
      chk("rst_data1", od1, 0);
      chk("rst_cnt1", oc1, 0);
      chk("rst_deq1", deq1, 0);

      // continuous supply, sink always ready
      rst = 1'b0;
      for (int i = 2; i <= 20; i++) begin push(0, i); push(1, i); end
      rdy[0] = 1'b1; rdy[1] = 1'b1;
      repeat (20) tick();
      chk("rate_accepts0", acc[0], 9);
      chk("rate_accepts1", acc[1], 4);

      // sink stall with the first word presented
      do_reset();
      rdy[0] = 1'b0;
      for (int i = 1; i <= 8; i++) push(0, i);
      repeat (8) tick();
      chk("stall_valid", ov0, 1);
      chk("stall_data", od0, 64'h00000002_00000001);
      chk("stall_fifo_left", wr[0] - rd[0], 6);
      rdy[0] = 1'b1;
      acc[0] = 0;
      repeat (12) tick();
      chk("stall_accepts", acc[0], 4);
      chk("stall_no_loss", wr[0] - er[0], 0);

      // reset with a partial word captured
      do_reset();
      push(0, 5);
      tick();
      chk("partial_taken", rd[0] - er[0], 1);
      do_reset();
      chk("post_rst_valid", ov0, 0);
      push(0, 8); push(0, 9);
      acc[0] = 0;
      repeat (6) tick();
      chk("post_rst_accepts", acc[0], 1);

      // wide packer with sink ready toggling each cycle
      do_reset();
      for (int i = 1; i <= 8; i++) push(1, i);
      acc[1] = 0;
      for (int i = 0; i < 30; i++) begin
         rdy[1] = i[0];
         tick();
      end
      chk("toggle_accepts", acc[1], 2);
      chk("toggle_no_loss", wr[1] - er[1], 0);

`ifdef PACKER_FLUSH_EN
      do_reset();
      rdy[0] = 1'b0;
      push(0, 7);
      tick();
      fl[0] = 1'b1;
      grp[0] = 1;
      tick();
      fl[0] = 1'b0;
      tick();
      chk("flush_valid", ov0, 1);
      chk("flush_data", od0, 64'h00000000_00000007);
      chk("flush_cnt", oc0, 1);
      rdy[0] = 1'b1;
      tick();
      fl[0] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("flush_empty_valid", ov0, 0);
      end
      fl[0] = 1'b0;
`endif

      // random supply and backpressure, then drain
      do_reset();
      for (int i = 0; i < 400; i++) begin
         for (int d = 0; d < 2; d++) begin
            if ($urandom_range(0, 2) != 0) push(d, $urandom);
            rdy[d] = 1'($urandom_range(0, 1));
         end
         tick();
      end
      rdy[0] = 1'b1; rdy[1] = 1'b1;
      repeat (300) tick();
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rand_fifo_empty%0d", d), emp[d], 1);
         chk($sformatf("rand_leftover%0d", d), (wr[d] - er[d]) < ratio(d), 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
